// File: rtl/clarvi_part_sequencer.sv
// Byte-serial operand feeder and result collector around clarvi_ALU: issues one
// captured 64-bit instruction as eight byte parts and reassembles the result.
package clarvi_part_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU
  } alu_op_t;

  typedef struct packed {
    alu_op_t    op;
    logic       is32_bit_op;
    logic       use_imm;
    logic [2:0] instr_part;
    logic [7:0] immediate;
  } instr_t;

endpackage

module clarvi_part_sequencer
  import clarvi_part_sequencer_pkg::*;
#(
  parameter bit BACK_TO_BACK = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  instr_t      in_instr,
  input  logic [63:0] in_rs1,
  input  logic [63:0] in_rs2,
  input  logic [63:0] in_imm,
  input  logic [4:0]  in_rd,
  output instr_t      alu_instr,
  output logic [7:0]  alu_rs1,
  output logic [7:0]  alu_rs2,
  output logic        alu_stall,
  input  logic [7:0]  alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd
);

  localparam int unsigned XLEN   = 64;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PART_W = 3;
  localparam logic [PART_W-1:0] LAST_STEP = PART_W'(XLEN / BYTE_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [PART_W-1:0] step;
  instr_t            instr_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic [XLEN-1:0]   imm_q;

  logic              accept;
  instr_t            src_instr;
  logic [XLEN-1:0]   src_rs1;
  logic [XLEN-1:0]   src_rs2;
  logic [XLEN-1:0]   src_imm;
  logic [PART_W-1:0] src_step;
  logic [PART_W-1:0] src_part;
  instr_t            issue_instr;
  logic [7:0]        issue_rs1;
  logic [7:0]        issue_rs2;

  // Compares walk from the most significant byte; 32-bit right shifts walk the
  // low word top-down first, then the (sign-extension) high word.
  function automatic logic [PART_W-1:0] part_of(input instr_t i, input logic [PART_W-1:0] s);
    logic [PART_W-1:0] p;
    p = s;
    case (i.op)
      OP_SLT, OP_SLTU: p = ~s;
      OP_SRL, OP_SRA:  p = i.is32_bit_op ? (s ^ PART_W'(3)) : ~s;
      default:         p = s;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] byte_of(input logic [XLEN-1:0] v, input logic [PART_W-1:0] p);
    return v[{p, 3'b000} +: BYTE_W];
  endfunction

  // Acceptance window: idle, or the consume cycle of a finished result.
  always_comb begin
    in_ready = 1'b0;
    if (reset && !flush) begin
      case (state)
        IDLE:    in_ready = 1'b1;
        DONE:    in_ready = BACK_TO_BACK && out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;

  // Next part to present: first part of a new instruction, or the following step.
  always_comb begin
    src_instr = accept ? in_instr : instr_q;
    src_rs1   = accept ? in_rs1   : rs1_q;
    src_rs2   = accept ? in_rs2   : rs2_q;
    src_imm   = accept ? in_imm   : imm_q;
    src_step  = accept ? '0       : step + PART_W'(1);
    src_part  = part_of(src_instr, src_step);
    issue_instr            = src_instr;
    issue_instr.instr_part = src_part;
    issue_instr.immediate  = byte_of(src_imm, src_part);
    issue_rs1 = byte_of(src_rs1, src_part);
    issue_rs2 = byte_of(src_rs2, src_part);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      step       <= '0;
      instr_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      alu_instr  <= '0;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
      alu_stall  <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
    end else if (flush) begin
      state     <= IDLE;
      step      <= '0;
      alu_stall <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            instr_q   <= in_instr;
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
            imm_q     <= in_imm;
            out_rd    <= in_rd;
            alu_instr <= issue_instr;
            alu_rs1   <= issue_rs1;
            alu_rs2   <= issue_rs2;
            alu_stall <= 1'b0;
            out_valid <= 1'b0;
            step      <= '0;
            state     <= RUN;
          end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        RUN: begin
          out_result[{alu_instr.instr_part, 3'b000} +: BYTE_W] <= alu_result;
          if (step == LAST_STEP) begin
            alu_stall <= 1'b1;
            out_valid <= 1'b1;
            step      <= '0;
            state     <= DONE;
          end else begin
            alu_instr <= issue_instr;
            alu_rs1   <= issue_rs1;
            alu_rs2   <= issue_rs2;
            step      <= src_step;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
